aes_block_queue: RTL and testbench
==================================

Name: aes_block_queue

Overview:
- Parametrised first-word-fall-through queue for 128-bit AES blocks/keys with valid/ready handshakes on both sides.
- Tags each entry with a new-key marker and the round constant (Rcon) for its key-expansion round.
- Sits between the block/key source and the key-expansion / round datapath; replaces the fixed single-purpose block queue.
- Adds depth, count, almost-full and backpressure.

Parameters:
- DATA_W, 128, width of one queued block; must be a multiple of 8.
- DEPTH, 8, number of entries; power of two, at least 2.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH; range 1..DEPTH.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  block/key to enqueue.
- in_new_key  in  1  entry starts a new key schedule (restarts Rcon).
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  queue accepts; equals !full.
- out_data  out  DATA_W  head entry data.
- out_new_key  out  1  head entry new-key tag.
- out_rcon  out  8  Rcon attached to head entry.
- out_valid  out  1  head valid; equals !empty.
- out_ready  in  1  consumer takes head.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, active-high): wr_ptr = rd_ptr = 0, count = 0, push Rcon register = 0x01.
  - After reset: empty = 1, full = 0, almost_full = 0, out_valid = 0, in_ready = 1.
  - out_data, out_new_key and out_rcon read storage, which is not reset. Their value is don't-care while out_valid = 0.
  - Reset mid-operation discards all entries; storage contents are not cleared.
- Push: occurs when in_valid && in_ready at a rising edge. Stores {in_data, in_new_key, rcon_e} at wr_ptr; wr_ptr increments modulo DEPTH.
- Rcon assignment at push:
  - If in_new_key = 1: rcon_e = 0x01, and the push Rcon register becomes 0x02.
  - Otherwise: rcon_e = push Rcon register, and the register becomes xtime(register).
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0x00), truncated to 8 bits.
  - Sequence: 01,02,04,08,10,20,40,80,1B,36,6C,...; no saturation.
  - The register changes only on an accepted push.
- Pop: occurs when out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- Head outputs: combinational from storage at rd_ptr (fall-through).
  - A push into an empty queue appears on out_* and out_valid in the cycle after the push edge.
  - There is no same-cycle bypass.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, in_ready = 0, so no push occurs even if a pop happens the same cycle (no pass-through when full).
  - When empty, out_valid = 0, so no pop occurs.
- Count update: count += push - pop. Flags derive combinationally from the count register.
- Pointer wrap: natural modulo-DEPTH wrap; DEPTH is a power of two.
- Ordering: strict FIFO; data, tag and rcon stay atomically aligned per entry.
- Protocol: the producer holds in_data stable while in_valid && !in_ready. Dropping in_valid without a handshake is legal and pushes nothing.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W = 128.
  - RCON_INIT = 8'h01.
  - RCON_POLY = 8'h1B.
  - function xtime.
- Sub-module aes_rcon_gen: 8-bit Rcon register with load-0x01 / advance controls, using xtime from the package.
- The FIFO storage, pointers and flags stay in aes_block_queue.

Test Plan:
- Reset: assert reset 2 cycles, then deassert → empty=1, full=0, almost_full=0, count=0, in_ready=1, out_valid=0.
- Fill/drain DEPTH=8: push 0x101112…1F first with new_key=1, then 7 more blocks, out_ready=0.
  - After the 6th push → almost_full=1.
  - After the 8th push → full=1, in_ready=0, count=8.
  - A 9th offer is held and not accepted.
  - Drain with out_ready=1 → data returned in order, rcon 01,02,04,08,10,20,40,80.
- Rcon wrap/restart: push 10 entries with new_key only on the first → rcon …80,1B,36.
  - Next push with new_key=1 → rcon 01; the push after it → 02.
- Simultaneous push/pop at count=3 for 5 cycles → count stays 3, outputs in order, no loss.
  - Then at full, assert in_valid and out_ready → only the pop occurs; count drops to 7.
- Pointer wrap: 20 push/pop cycles with varying out_ready duty → scoreboard matches data/tag/rcon across several wrap-arounds.
- Reset mid-operation: with count=5, assert reset for 1 cycle → count=0, empty=1, Rcon register 0x01.
  - Next non-new-key push → rcon 01.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES block/key datapath.
//   AES_BLOCK_W : width of one AES block or key in bits
//   RCON_INIT   : first round constant of a key schedule
//   RCON_POLY   : GF(2^8) reduction byte applied when xtime overflows
//   xtime()     : multiply a byte by x in GF(2^8)
package aes_pkg;

    localparam int         AES_BLOCK_W = 128;
    localparam logic [7:0] RCON_INIT   = 8'h01;
    localparam logic [7:0] RCON_POLY   = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant generator for the push side of the block queue.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset, register returns to RCON_INIT
//   i_advance  an entry is being accepted this cycle
//   i_restart  the entry being offered starts a new key schedule
//   o_rcon_e   Rcon to attach to the entry being offered
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_advance,
    input  logic       i_restart,
    output logic [7:0] o_rcon_e
);

    logic [7:0] r_rcon;
    logic [7:0] w_rcon_e;

    // A new key always starts at RCON_INIT regardless of where the previous
    // schedule had got to; the register then holds the constant for the
    // following entry.
    assign w_rcon_e = i_restart ? RCON_INIT : r_rcon;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rcon <= RCON_INIT;
        end else if (i_advance) begin
            r_rcon <= xtime(w_rcon_e);
        end
    end

    assign o_rcon_e = w_rcon_e;

endmodule

// File: rtl/aes_block_queue.sv
// First-word-fall-through queue of AES blocks/keys. Each entry carries its
// new-key marker and the Rcon for its key-expansion round.
// Ports:
//   clock, reset                         clock and synchronous active-high reset
//   in_data/in_new_key/in_valid/in_ready  producer side (valid/ready)
//   out_data/out_new_key/out_rcon         head entry, combinational from storage
//   out_valid/out_ready                   consumer side (valid/ready)
//   empty/full/almost_full/count          occupancy status
module aes_block_queue
    import aes_pkg::*;
#(
    parameter int DATA_W   = AES_BLOCK_W,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_new_key,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_new_key,
    output logic [7:0]               out_rcon,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_key  [DEPTH];
    logic [7:0]        r_mem_rcon [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_rcon_e;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // No pass-through when full: a pop in the same cycle does not open a slot
    // for the producer until the next cycle.
    assign w_push = in_valid && !w_full;
    assign w_pop  = out_ready && !w_empty;

    aes_rcon_gen u_rcon_gen (
        .clock     (clock),
        .reset     (reset),
        .i_advance (w_push),
        .i_restart (in_new_key),
        .o_rcon_e  (w_rcon_e)
    );

    // Storage is deliberately not reset; out_valid qualifies the head.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_key[r_wr_ptr]  <= in_new_key;
            r_mem_rcon[r_wr_ptr] <= w_rcon_e;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data    = r_mem_data[r_rd_ptr];
    assign out_new_key = r_mem_key[r_rd_ptr];
    assign out_rcon    = r_mem_rcon[r_rd_ptr];
    assign out_valid   = !w_empty;
    assign in_ready    = !w_full;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CNT_W'(AFULL_TH));
    assign count       = r_count;

endmodule

// File: tb/tb_aes_block_queue.sv
module tb_aes_block_queue;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] in_data;
    logic         in_new_key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_new_key;
    logic [7:0]   out_rcon;
    logic         out_valid;
    logic         out_ready;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic [3:0]   count;

    aes_block_queue #(.DATA_W(128), .DEPTH(8), .AFULL_TH(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_new_key  (in_new_key),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_new_key (out_new_key),
        .out_rcon    (out_rcon),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] d;
        logic         k;
        logic [7:0]   r;
    } ent_t;

    int         total = 0;
    int         bad   = 0;
    int         mc    = 0;       // model occupancy
    logic [7:0] mr    = 8'h01;   // model push Rcon register
    ent_t       sb[$];
    logic [7:0] popped[$];

    logic [7:0] tbl1 [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] tbl2 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h1B, 8'h36};

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Block i holds bytes (16*i+0x10) .. (16*i+0x1F), most significant first.
    function automatic logic [127:0] blk(input int i);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) begin
            v[127-8*j -: 8] = 8'((16 * i) + 16 + j);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the current inputs; the model predicts the
    // handshakes, checks the popped head and the resulting occupancy.
    task automatic cyc();
        bit   pu;
        bit   po;
        ent_t e;
        ent_t h;
        pu = in_valid && (mc != 8);
        po = out_ready && (mc != 0);
        chk("in_ready", in_ready, (mc != 8));
        chk("out_valid", out_valid, (mc != 0));
        if (po) begin
            h = sb.pop_front();
            chk("head_data", out_data, h.d);
            chk("head_key", out_new_key, h.k);
            chk("head_rcon", out_rcon, h.r);
            popped.push_back(out_rcon);
        end
        if (pu) begin
            e.r = in_new_key ? 8'h01 : mr;
            mr  = xt(e.r);
            e.d = in_data;
            e.k = in_new_key;
            sb.push_back(e);
        end
        mc = mc + int'(pu) - int'(po);
        @(posedge clock);
        @(negedge clock);
        chk("count", count, mc);
        chk("empty", empty, (mc == 0));
        chk("full", full, (mc == 8));
        chk("almost_full", almost_full, (mc >= 6));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && mc != 0; n++) cyc();
        chk("drain_done", empty, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_new_key = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;

        // Reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_afull", almost_full, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);

        // Fill to DEPTH with the consumer stalled
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            in_data    = blk(i);
            in_new_key = (i == 0);
            cyc();
            if (i == 0) begin
                chk("ff_head_data", out_data, blk(0));
                chk("ff_head_valid", out_valid, 1'b1);
            end
            if (i == 4) chk("afull_at5", almost_full, 1'b0);
            if (i == 5) chk("afull_at6", almost_full, 1'b1);
        end
        chk("full_at8", full, 1'b1);
        chk("in_ready_at8", in_ready, 1'b0);
        chk("count_at8", count, 4'd8);

        // Ninth offer is held off
        in_data    = blk(8);
        in_new_key = 1'b0;
        cyc();
        chk("ninth_held", count, 4'd8);

        // Drain in order with the fixed Rcon sequence
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t1_data", out_data, blk(i));
            chk("t1_rcon", out_rcon, tbl1[i]);
            chk("t1_key", out_new_key, (i == 0));
            cyc();
        end
        chk("t1_empty", empty, 1'b1);

        // Rcon across the 0x80 -> 0x1B reduction, then restart
        popped.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            in_data    = blk(20 + i);
            in_new_key = (i == 0);
            cyc();
        end
        drain();
        chk("t2_popped_n", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) chk("t2_rcon", popped[i], tbl2[i]);
        popped.delete();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = blk(40);
        in_new_key = 1'b1;
        cyc();
        in_data    = blk(41);
        in_new_key = 1'b0;
        cyc();
        drain();
        chk("t2_restart_n", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t2_restart_rcon0", popped[0], 8'h01);
            chk("t2_restart_rcon1", popped[1], 8'h02);
        end

        // Simultaneous push/pop at count 3, then pop-only at full
        out_ready  = 1'b0;
        in_new_key = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = blk(50 + i);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = blk(53 + i);
            cyc();
            chk("t3_count3", count, 4'd3);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = blk(58 + i);
            cyc();
        end
        chk("t3_full", full, 1'b1);
        in_data   = blk(63);
        out_ready = 1'b1;
        cyc();
        chk("t3_pop_only", count, 4'd7);
        drain();

        // Pointer wrap with varying consumer duty
        for (int i = 0; i < 20; i++) begin
            in_valid   = 1'b1;
            in_data    = blk(70 + i);
            in_new_key = (i % 7 == 0);
            out_ready  = (i % 3 != 0);
            cyc();
        end
        drain();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_data    = blk(100 + i);
            in_new_key = (i == 4);
            out_ready  = (i % 2 == 1);
            cyc();
        end
        drain();

        // Reset with entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_data    = blk(120 + i);
            in_new_key = (i == 0);
            cyc();
        end
        chk("t5_count5", count, 4'd5);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mc = 0;
        mr = 8'h01;
        sb.delete();
        chk("t5_count0", count, 4'd0);
        chk("t5_empty", empty, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        in_valid   = 1'b1;
        in_data    = blk(130);
        in_new_key = 1'b0;
        cyc();
        chk("t5_rcon01", out_rcon, 8'h01);
        chk("t5_data", out_data, blk(130));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
